ldc_arbiter: RTL and testbench
==============================

LDC_ARBITER -- requirements
Module: ldc_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of cycles to wait for engine completion.
REQ-003 Port clk  in  1  clock; all state updates on posedge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port req  in  N_REQ  per-requester request level, held until that requester's ack.
REQ-006 Port req_x  in  N_REQ*16  per-requester angle x, Q5.11, slice i = bits [16i+15:16i].
REQ-007 Port req_v  in  N_REQ*16  per-requester speed v, Q5.11, same slicing.
REQ-008 Port ack  out  N_REQ  one-cycle completion pulse, one-hot or zero.
REQ-009 Port resp_data  out  16  v*cos(x) result in Q5.11, valid only while ack is nonzero.
REQ-010 Port resp_err  out  1  timeout flag, valid only while ack is nonzero.
REQ-011 Port busy  out  1  high whenever state is not IDLE.
REQ-012 Port eng_start  out  1  start to the cosine-distance engine.
REQ-013 Port eng_x, eng_v  out  16 each  operands to the engine.
REQ-014 Port eng_done  in  1  engine done level, which stays high until the engine's next run clears it.
REQ-015 Port eng_distance  in  16  engine result.

Function
REQ-016 The FSM SHALL have states IDLE, LAUNCH, WAIT and RESP, all registered.
REQ-017 IDLE: when any req bit is high, the block SHALL pick a winner round-robin, searching from (last_grant+1) mod N_REQ upward with wrap-around, and go to LAUNCH.
REQ-018 On that transition the block SHALL latch the winner's index, req_x slice and req_v slice into internal registers.
REQ-019 eng_x and eng_v SHALL be driven only from the latched registers and SHALL stay stable from LAUNCH through RESP, since the engine reads x and v across the whole run.
REQ-020 LAUNCH: the block SHALL assert eng_start for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-021 WAIT: the block SHALL hold eng_start low.
REQ-022 WAIT: completion SHALL be a rising edge of eng_done (eng_done=1 and registered previous eng_done=0); a stale high eng_done from the previous run SHALL NOT count as completion.
REQ-023 WAIT: on completion the block SHALL capture eng_distance, set err=0 and go to RESP.
REQ-024 WAIT: the timeout counter SHALL increment every cycle; when it reaches TIMEOUT with no completion, the block SHALL set the result to 0, set err=1 and go to RESP.
REQ-025 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-026 RESP: for one cycle the block SHALL set ack[winner]=1 and drive resp_data and resp_err from the captured values.
REQ-027 RESP: the block SHALL update last_grant to the winner and go to IDLE.
REQ-028 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-029 Request changes during LAUNCH, WAIT or RESP SHALL be ignored until the block is back in IDLE.
REQ-030 Latency from a granted request to ack SHALL be 3 cycles plus the engine latency; with an idle engine and a single requester, the IDLE-to-RESP path SHALL use no extra cycles.
REQ-031 There SHALL be no arithmetic on the data path: results pass through as 16-bit two's complement.
REQ-032 The timeout counter SHALL be clog2(TIMEOUT+1) bits wide and SHALL saturate.

Reset
REQ-033 While rst is high the state SHALL be IDLE and ack=0, resp_data=0, resp_err=0, busy=0, eng_start=0, eng_x=0 and eng_v=0.
REQ-034 While rst is high last_grant SHALL be N_REQ-1, so requester 0 has first priority, and the timeout counter and previous-done register SHALL be 0.
REQ-035 Reset in any state, including mid-WAIT, SHALL abandon the operation without issuing an ack; the engine is reset by the same rst.

Structure
REQ-036 Package ldc_pkg SHALL hold the Q5.11 width constant (16), the FSM state enum, and the default N_REQ and TIMEOUT values.
REQ-037 Round-robin selection SHALL be the sub-module ldc_rr_pick: combinational, taking req and last_grant and producing a one-hot grant and a valid bit.

Verification
REQ-038 Single request: req0 with x=2048, v=2048 on the real engine -> exactly one ack[0] pulse, resp_data=1106 (±2 LSB), resp_err=0.
REQ-039 All four requesting at once: x=0 with v=2893, 2048, 1024, 512 -> ack order 0,1,2,3, resp_data ≈ v each time, one operation at a time, eng_start pulsed exactly 4 times.
REQ-040 Fairness: req0 and req2 held high continuously, re-asserting after each ack -> grants alternate 0,2,0,2; no starvation over 20 grants.
REQ-041 Stale done: run two back-to-back operations -> the second ack does not occur before eng_done has gone low and then high again; the second result is x=4289, v=2048 -> -1023.
REQ-042 Timeout: stub engine that holds eng_done low -> ack with resp_err=1 and resp_data=0 exactly TIMEOUT cycles after WAIT entry.
REQ-043 Reset mid-WAIT: assert rst 10 cycles after eng_start -> no ack, outputs zero; a request after reset is served normally starting with requester 0.

Source files
------------

// File: rtl/ldc_pkg.sv
// Shared constants, FSM state type and operand payload for the LDC request arbiter.
package ldc_pkg;

    localparam int unsigned Q_W         = 16;
    localparam int unsigned DEF_N_REQ   = 4;
    localparam int unsigned DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic [Q_W-1:0] x;
        logic [Q_W-1:0] v;
    } ldc_op_t;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ldc_rr_pick.sv
// Combinational round-robin picker: searches upward from last_grant+1 with wrap-around.
module ldc_rr_pick
    import ldc_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]          req,
    input  logic [idx_w(N_REQ)-1:0]   last_grant,
    output logic [N_REQ-1:0]          grant,
    output logic                      valid
);

    localparam int unsigned IDX_W = idx_w(N_REQ);

    always_comb begin
        int unsigned j;
        grant = '0;
        valid = 1'b0;
        j     = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            j = (32'(last_grant) + off) % N_REQ;
            if (!valid && req[j[IDX_W-1:0]]) begin
                grant[j[IDX_W-1:0]] = 1'b1;
                valid               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldc_arbiter.sv
// Round-robin arbiter sharing one cosine-distance engine among N_REQ requesters,
// with edge-detected completion and a saturating timeout.
module ldc_arbiter
    import ldc_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*Q_W-1:0]   req_x,
    input  logic [N_REQ*Q_W-1:0]   req_v,
    output logic [N_REQ-1:0]       ack,
    output logic [Q_W-1:0]         resp_data,
    output logic                   resp_err,
    output logic                   busy,
    output logic                   eng_start,
    output logic [Q_W-1:0]         eng_x,
    output logic [Q_W-1:0]         eng_v,
    input  logic                   eng_done,
    input  logic [Q_W-1:0]         eng_distance
);

    localparam int unsigned IDX_W = idx_w(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, win_q, pick_idx;
    logic [N_REQ-1:0]   pick_grant;
    logic               pick_valid;
    ldc_op_t            op_q, pick_op;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q, done_rise, timeout_hit;

    ldc_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // Encode the one-hot winner and select its operand slices.
    always_comb begin
        pick_idx = '0;
        pick_op  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx  = IDX_W'(i);
                pick_op.x = req_x[i*Q_W +: Q_W];
                pick_op.v = req_v[i*Q_W +: Q_W];
            end
        end
    end

    // Only a fresh rising edge counts; a done level left over from the last run does not.
    assign done_rise   = eng_done & ~done_q;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    assign eng_x = op_q.x;
    assign eng_v = op_q.v;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (pick_valid) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT:   if (done_rise || timeout_hit) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(N_REQ - 1);
            win_q        <= '0;
            op_q         <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            ack          <= '0;
            resp_data    <= '0;
            resp_err     <= 1'b0;
            busy         <= 1'b0;
            eng_start    <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= eng_done;
            busy      <= (state_d != ST_IDLE);
            eng_start <= (state_d == ST_LAUNCH);
            ack       <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        win_q <= pick_idx;
                        op_q  <= pick_op;
                    end
                end
                ST_LAUNCH: cnt_q <= '0;
                ST_WAIT: begin
                    if (cnt_q != CNT_W'(TIMEOUT)) cnt_q <= cnt_q + CNT_W'(1);
                    // Completion takes priority over a coincident timeout.
                    if (state_d == ST_RESP) begin
                        ack       <= N_REQ'(1) << win_q;
                        resp_data <= done_rise ? eng_distance : '0;
                        resp_err  <= ~done_rise;
                    end
                end
                ST_RESP: last_grant_q <= win_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ldc_arbiter.sv
// Directed bench for ldc_arbiter with a behavioural cosine-distance engine model.
module tb_ldc_arbiter;
    import ldc_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*16-1:0] req_x, req_v;
    logic [N-1:0]    ack;
    logic [15:0]     resp_data;
    logic            resp_err, busy, eng_start;
    logic [15:0]     eng_x, eng_v;
    logic            eng_done;
    logic [15:0]     eng_distance;

    int checks   = 0;
    int failures = 0;

    int eng_lat  = 4;
    bit eng_hang = 0;
    int e_cnt;
    bit e_busy;

    int start_cnt = 0;
    int ack_cnt   = 0;
    int overlap_err = 0;
    int outstanding = 0;
    bit done_low_seen = 0;

    always #5 clk = ~clk;

    ldc_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_x        (req_x),
        .req_v        (req_v),
        .ack          (ack),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .busy         (busy),
        .eng_start    (eng_start),
        .eng_x        (eng_x),
        .eng_v        (eng_v),
        .eng_done     (eng_done),
        .eng_distance (eng_distance)
    );

    function automatic logic [15:0] eng_model(input logic [15:0] x, input logic [15:0] v);
        real xr, vr, r;
        xr = $itor($signed(x)) / 2048.0;
        vr = $itor($signed(v)) / 2048.0;
        r  = vr * $cos(xr) * 2048.0;
        return 16'($rtoi(r));
    endfunction

    // Engine: done stays high until the second cycle of the next run.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_done     <= 1'b0;
            eng_distance <= '0;
            e_busy       <= 1'b0;
            e_cnt        <= 0;
        end else if (eng_start) begin
            e_busy <= 1'b1;
            e_cnt  <= eng_lat;
        end else if (e_busy) begin
            if (e_cnt == eng_lat) eng_done <= 1'b0;
            if (e_cnt == 1) begin
                e_busy <= 1'b0;
                if (!eng_hang) begin
                    eng_done     <= 1'b1;
                    eng_distance <= eng_model(eng_x, eng_v);
                end
            end
            e_cnt <= e_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
        end else begin
            if (eng_start) begin
                start_cnt++;
                if (outstanding != 0) overlap_err++;
                outstanding++;
                done_low_seen = 0;
            end else if (!eng_done) begin
                done_low_seen = 1;
            end
            if (ack != '0) begin
                ack_cnt++;
                outstanding--;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] v);
        req_x[i*16 +: 16] = x;
        req_v[i*16 +: 16] = v;
    endtask

    task automatic wait_ack(input int budget, output logic [N-1:0] a, output logic [15:0] d,
                            output logic e, output int waited);
        a = '0; d = '0; e = 1'b0; waited = 0;
        for (int k = 0; k < budget; k++) begin
            tick();
            waited = k + 1;
            if (ack != '0) begin
                a = ack; d = resp_data; e = resp_err;
                return;
            end
        end
    endtask

    task automatic wait_start(input int budget, output bit seen);
        seen = 0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (eng_start) begin
                seen = 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        tick();
        checks++;
        if ({ack, resp_data, resp_err, eng_start, eng_x, eng_v} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ack=%b data=%h err=%b start=%b x=%h v=%h exp all zero",
                     ack, resp_data, resp_err, eng_start, eng_x, eng_v);
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || eng_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_held_idle got busy=%b start=%b exp 0 0", busy, eng_start);
        end
        req = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [N-1:0] a; logic [15:0] d; logic e; int w; bit s; int diff, base;
        do_reset();
        set_op(0, 16'd2048, 16'd2048);
        req = 4'b0001;
        wait_start(10, s);
        checks++;
        if (!s || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_start got seen=%0d busy=%b exp 1 1", s, busy);
        end
        base = ack_cnt;
        wait_ack(50, a, d, e, w);
        req = '0;
        diff = int'($signed(d)) - 1106;
        checks++;
        if (a !== 4'b0001 || e !== 1'b0 || diff > 2 || diff < -2) begin
            failures++;
            $display("FAIL single_result got ack=%b data=%0d err=%b exp 0001 1106 0", a, $signed(d), e);
        end
        checks++;
        if (w != eng_lat + 2) begin
            failures++;
            $display("FAIL single_latency got %0d exp %0d", w, eng_lat + 2);
        end
        repeat (10) tick();
        checks++;
        if (ack_cnt - base != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_one_pulse got acks=%0d busy=%b exp 1 0", ack_cnt - base, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a; logic [15:0] d; logic e; int w; int diff;
        do_reset();
        set_op(0, 16'd2048, 16'd2048);
        set_op(1, 16'd4289, 16'd2048);
        req = 4'b0011;
        wait_ack(50, a, d, e, w);
        req = 4'b0010;
        diff = int'($signed(d)) - 1106;
        checks++;
        if (a !== 4'b0001 || diff > 2 || diff < -2) begin
            failures++;
            $display("FAIL b2b_first got ack=%b data=%0d exp 0001 1106", a, $signed(d));
        end
        wait_ack(50, a, d, e, w);
        req = '0;
        diff = int'($signed(d)) + 1023;
        checks++;
        if (a !== 4'b0010 || e !== 1'b0 || diff > 2 || diff < -2) begin
            failures++;
            $display("FAIL b2b_second got ack=%b data=%0d err=%b exp 0010 -1023 0", a, $signed(d), e);
        end
        checks++;
        if (!done_low_seen) begin
            failures++;
            $display("FAIL b2b_stale_done got done_low_seen=0 exp 1");
        end
        repeat (3) tick();
    endtask

    task automatic test_all_four();
        logic [N-1:0] a; logic [15:0] d; logic e; int w; int diff, base;
        int vs [4] = '{2893, 2048, 1024, 512};
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 16'd0, 16'(vs[i]));
        base = start_cnt;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_ack(50, a, d, e, w);
            req = req & ~a;
            diff = int'($signed(d)) - vs[k];
            checks++;
            if (a !== (4'b0001 << k) || diff > 2 || diff < -2) begin
                failures++;
                $display("FAIL all4_ack%0d got ack=%b data=%0d exp %b %0d",
                         k, a, $signed(d), 4'b0001 << k, vs[k]);
            end
        end
        req = '0;
        repeat (10) tick();
        checks++;
        if (start_cnt - base != 4 || overlap_err != 0) begin
            failures++;
            $display("FAIL all4_starts got starts=%0d overlaps=%0d exp 4 0", start_cnt - base, overlap_err);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] a, exp_a; logic [15:0] d; logic e; int w; int c0, c2;
        do_reset();
        set_op(0, 16'd0, 16'd300);
        set_op(2, 16'd0, 16'd700);
        c0 = 0; c2 = 0;
        req = 4'b0101;
        for (int k = 0; k < 20; k++) begin
            wait_ack(50, a, d, e, w);
            if (k == 19) req = '0;
            exp_a = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            if (a == 4'b0001) c0++;
            if (a == 4'b0100) c2++;
            checks++;
            if (a !== exp_a) begin
                failures++;
                $display("FAIL fair_grant%0d got %b exp %b", k, a, exp_a);
            end
        end
        checks++;
        if (c0 != 10 || c2 != 10) begin
            failures++;
            $display("FAIL fair_counts got c0=%0d c2=%0d exp 10 10", c0, c2);
        end
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        logic [N-1:0] a; logic [15:0] d; logic e; int w; bit s;
        do_reset();
        eng_hang = 1;
        set_op(0, 16'd2048, 16'd2048);
        req = 4'b0001;
        wait_start(10, s);
        wait_ack(TO + 20, a, d, e, w);
        req = '0;
        checks++;
        if (!s || a !== 4'b0001 || e !== 1'b1 || d !== 16'd0) begin
            failures++;
            $display("FAIL timeout_result got seen=%0d ack=%b err=%b data=%h exp 1 0001 1 0000", s, a, e, d);
        end
        checks++;
        if (w != TO + 1) begin
            failures++;
            $display("FAIL timeout_latency got %0d exp %0d", w, TO + 1);
        end
        eng_hang = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_wait();
        logic [N-1:0] a; logic [15:0] d; logic e; int w; bit s; int base, diff;
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 16'd0, 16'(100 * (i + 1)));
        req = 4'b0001;
        wait_ack(50, a, d, e, w);
        req = '0;
        repeat (2) tick();
        eng_lat = 40;
        req = 4'b0011;
        wait_start(10, s);
        repeat (10) tick();
        base = ack_cnt;
        rst = 1'b1;
        tick();
        checks++;
        if ({ack, resp_data, resp_err, busy, eng_start, eng_x, eng_v} !== '0) begin
            failures++;
            $display("FAIL midwait_outputs got ack=%b data=%h err=%b busy=%b start=%b x=%h v=%h exp all zero",
                     ack, resp_data, resp_err, busy, eng_start, eng_x, eng_v);
        end
        req = '0;
        tick();
        rst = 1'b0;
        eng_lat = 4;
        repeat (3) tick();
        checks++;
        if (ack_cnt != base || !s) begin
            failures++;
            $display("FAIL midwait_no_ack got acks=%0d seen=%0d exp 0 1", ack_cnt - base, s);
        end
        req = 4'b1111;
        wait_ack(50, a, d, e, w);
        req = '0;
        diff = int'($signed(d)) - 100;
        checks++;
        if (a !== 4'b0001 || e !== 1'b0 || diff > 2 || diff < -2) begin
            failures++;
            $display("FAIL midwait_after got ack=%b data=%0d err=%b exp 0001 100 0", a, $signed(d), e);
        end
        repeat (3) tick();
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        req_x = '0;
        req_v = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_all_four();
        test_fairness();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit exceeded");
        $fatal(1, "time limit");
    end

endmodule
